alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Issue/writeback sequencer that sits directly upstream of the combinational 8-bit ALU. It owns a small register file and accepts one instruction at a time over a valid/ready handshake. It drives registered operands, carry and 6-bit select into the ALU, captures the ALU result into the destination register, and presents it on a valid/ready result port. It turns the purely combinational ALU into a usable sequential datapath.

Parameters:
WIDTH, 8, datapath width; must equal the ALU size parameter
NREG, 4, number of registers in the file
AW, 2, register address width, clog2(NREG)

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid&in_ready
in_ld  in  1  1 = load-immediate, 0 = ALU op
in_sel  in  6  ALU select: [5:4] shift, [3] logic(1)/arith(0), [2:0] function
in_cin  in  1  carry-in for ALU op
in_rd  in  AW  destination register
in_rs1  in  AW  operand A register
in_rs2  in  AW  operand B register
in_imm  in  WIDTH  immediate for load
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_cin  out  1  to ALU cin
alu_sel  out  6  to ALU sel
alu_y  in  WIDTH  from ALU y
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid&out_ready
out_data  out  WIDTH  result (ALU y or immediate)
out_rd  out  AW  register written
dbg_addr  in  AW  debug read address
dbg_data  out  WIDTH  combinational read of rf[dbg_addr]

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n low at a clk edge): state=IDLE; all rf entries=0; alu_a=alu_b=0, alu_cin=0, alu_sel=0; out_valid=0, out_data=0, out_rd=0. in_ready=0 while rst_n is low.
- FSM states:
  - IDLE: in_ready=1. On accept, latch rd/ld/imm.
    - If in_ld=1, write in_imm to rf[in_rd] and out_data at the same edge, then go to RESP.
    - If in_ld=0, load alu_a=rf[rs1], alu_b=rf[rs2], alu_cin=in_cin, alu_sel=in_sel (values as of before the edge), then go to EXEC.
  - EXEC: one cycle, in_ready=0. ALU inputs are stable for the whole cycle. At the closing edge: rf[rd]<=alu_y, out_data<=alu_y, out_rd<=rd, out_valid<=1, then go to RESP.
  - RESP: out_valid=1. out_data and out_rd are held stable until out_ready. On out_valid&out_ready: out_valid<=0, go to IDLE.
- Latency, ALU op: accept at edge E0, capture at E1, out_valid high from E1. Load: out_valid high from E0.
- Throughput: one instruction per 3 cycles minimum (IDLE, EXEC, RESP). No pipelining, so no hazards; rs=rd reads the old value.
- alu_a, alu_b, alu_cin and alu_sel hold their last values outside EXEC. They are never used combinationally from in_*.
- Arithmetic width: alu_y is taken as WIDTH bits; wrap-around is the ALU's, with no carry-out or flags.
- in_valid is ignored outside IDLE. in_* may change freely while in_ready=0.
- out_ready asserted with out_valid=0 has no effect.
- Reset mid-EXEC or mid-RESP: abandon the instruction. No rf write occurs if reset coincides with the EXEC closing edge. out_valid=0 after that edge.
- dbg_data reflects rf contents combinationally and shows a write the cycle after its edge.

Decomposition:
- Shared package alu_pkg:
  - field constants SEL_SHR=2'b00, SEL_SHL=2'b11, SEL_PASS=2'b01, LOGIC_BIT=1'b1;
  - function codes ARITH_ADDC=3'b001, ARITH_SUB=3'b110, LOGIC_AND=3'b000, etc.;
  - FSM state encoding IDLE/EXEC/RESP.
- One sub-module: alu_regfile (NREG×WIDTH, one sync write port, two async read ports plus one debug read port, sync active-low clear).

Test Plan:
- Reset then load R1=0x0F, R2=0x03 -> each load gives out_valid one cycle after accept with out_data=0x0F/0x03; dbg shows R1=0x0F, R2=0x03.
- ALU op rd=3, rs1=1, rs2=2, sel=6'b010001, cin=1 -> alu_a=0x0F and alu_b=0x03 during EXEC; out_data=0x13, R3=0x13.
- sel=6'b010110 (sub) -> 0x0C; sel=6'b111000 (AND, shift left) -> 0x06; sel=6'b000000 (pass a, shift right) -> 0x07.
- R1=0xFF, R2=0x01, sel=6'b010100 -> out_data=0x00 (wrap).
- Hold out_ready=0 for 5 cycles after a result while toggling in_valid -> out_valid, out_data and out_rd stay stable; in_ready=0; no new accept. The next accept occurs the cycle after the handshake.
- Assert rst_n=0 during EXEC of a write to R3 (R3=0x13 beforehand) -> out_valid=0, R3=0x00 from the reset clear, and no stale result is presented after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue sequencer: select-field encodings and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

   // Shift field, sel[5:4]
   localparam logic [1:0] SEL_SHR   = 2'b00;
   localparam logic [1:0] SEL_PASS  = 2'b01;
   localparam logic [1:0] SEL_SHL   = 2'b11;

   // sel[3]: logic unit when set, arithmetic unit when clear
   localparam logic       LOGIC_BIT = 1'b1;

   // Function field, sel[2:0], arithmetic unit
   localparam logic [2:0] ARITH_PASSA = 3'b000;
   localparam logic [2:0] ARITH_ADDC  = 3'b001;
   localparam logic [2:0] ARITH_ADD   = 3'b100;
   localparam logic [2:0] ARITH_SUB   = 3'b110;

   // Function field, sel[2:0], logic unit
   localparam logic [2:0] LOGIC_AND   = 3'b000;
   localparam logic [2:0] LOGIC_OR    = 3'b001;
   localparam logic [2:0] LOGIC_XOR   = 3'b010;

   // Sequencer states
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] RESP = 2'b10;

   // Assemble a 6-bit ALU select from its three fields.
   function automatic logic [5:0] mk_sel(input logic [1:0] sh, input logic lg,
                                         input logic [2:0] fn);
      return {sh, lg, fn};
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREG x WIDTH, one synchronous write port, two async read ports, one async debug read.
// Latency: write visible on the read ports the cycle after its clock edge; reads are combinational.
// Backpressure: none; a write is taken on every edge where we is high.
//
// Ports: clk, rst_n (sync active-low clear of every entry), we/waddr/wdata (write),
//        raddr_a/rdata_a, raddr_b/rdata_b (operand reads), dbg_addr/dbg_data (debug read).
module alu_regfile #(
   parameter int WIDTH = 8,
   parameter int NREG  = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   logic [WIDTH-1:0] rf [NREG];

   // Reset takes priority, so a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
      end else if (we) begin
         rf[waddr] <= wdata;
      end
   end

   assign rdata_a  = rf[raddr_a];
   assign rdata_b  = rf[raddr_b];
   assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of a combinational ALU: registers operands, captures y into the RF.
// Latency: load-immediate result valid the cycle after accept; ALU op result valid two cycles after accept.
// Backpressure: one instruction in flight; in_ready low from accept until the result handshake completes.
//
// Ports: in_* instruction handshake (ld/sel/cin/rd/rs1/rs2/imm), alu_a/alu_b/alu_cin/alu_sel to the ALU,
//        alu_y back from it, out_* result handshake (data + destination register), dbg_* RF debug read.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREG  = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_ld,
   input  logic [5:0]       in_sel,
   input  logic             in_cin,
   input  logic [AW-1:0]    in_rd,
   input  logic [AW-1:0]    in_rs1,
   input  logic [AW-1:0]    in_rs2,
   input  logic [WIDTH-1:0] in_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic [5:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_rd,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   logic [1:0]       state;
   logic [AW-1:0]    rd_q;
   logic             accept;
   logic             rf_we;
   logic [AW-1:0]    rf_waddr;
   logic [WIDTH-1:0] rf_wdata;
   logic [WIDTH-1:0] rs1_dat;
   logic [WIDTH-1:0] rs2_dat;

   // in_ready is gated by rst_n so nothing is accepted on a reset edge.
   assign in_ready = rst_n && (state == IDLE);
   assign accept   = in_valid && in_ready;

   // Two writers share the single RF write port: a load at its accept edge,
   // and the ALU result at the edge closing EXEC. They can never coincide.
   assign rf_we    = (accept && in_ld) || (state == EXEC);
   assign rf_waddr = (state == EXEC) ? rd_q  : in_rd;
   assign rf_wdata = (state == EXEC) ? alu_y : in_imm;

   alu_regfile #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .AW    (AW)
   ) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .raddr_a  (in_rs1),
      .rdata_a  (rs1_dat),
      .raddr_b  (in_rs2),
      .rdata_b  (rs2_dat),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_q      <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_cin   <= 1'b0;
         alu_sel   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_rd    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rd_q <= in_rd;
                  if (in_ld) begin
                     out_data  <= in_imm;
                     out_rd    <= in_rd;
                     out_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     // Operands come from the RF as it stood before this edge,
                     // so rs == rd reads the old value.
                     alu_a   <= rs1_dat;
                     alu_b   <= rs2_dat;
                     alu_cin <= in_cin;
                     alu_sel <= in_sel;
                     state   <= EXEC;
                  end
               end
            end
            EXEC: begin
               out_data  <= alu_y;
               out_rd    <= rd_q;
               out_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
